// File: rtl/rps_move_gen.sv
// Rock-paper-scissors round controller: debounces the player's one-hot buttons,
// draws the computer move from a free-running LFSR, and presents both moves for a reveal window.
module rps_move_gen #(
  parameter int          DEBOUNCE_CYCLES = 500000,
  parameter int          HOLD_CYCLES     = 50000000,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [2:0] user_raw,
  output logic [2:0] user,
  output logic [2:0] compu,
  output logic       round_valid,
  output logic       busy,
  output logic [7:0] round_cnt
);

  localparam int          DB_W      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int          HOLD_W    = $clog2(HOLD_CYCLES + 1);
  localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [15:0] LFSR_MASK = 16'hB400;
  localparam logic [15:0] SEED      = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REVEAL,
    ST_RELEASE
  } state_t;

  logic [2:0]        s1, s2, s2_prev;
  logic [DB_W-1:0]   db_cnt;
  logic              stable;
  logic              s2_one_hot;
  logic [15:0]       lfsr, lfsr_next;
  logic [1:0]        move_sel;
  logic [2:0]        move_pick;

  state_t            state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_d;
  logic [2:0]        user_d, compu_d;
  logic              valid_d, busy_d;
  logic [7:0]        round_cnt_d;

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge value of its neighbours, regardless of block order.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      s1      <= '0;
      s2      <= '0;
      s2_prev <= '0;
      db_cnt  <= '0;
    end else begin
      s1      <= user_raw;
      s2      <= s1;
      s2_prev <= s2;
      if (s2 != s2_prev)
        db_cnt <= '0;
      else if (db_cnt != DB_MAX)
        db_cnt <= db_cnt + 1'b1;
    end
  end

  // A saturated count left over from the previous level must not vouch for a new one.
  assign stable     = (db_cnt == DB_MAX) && (s2 == s2_prev);
  assign s2_one_hot = (s2 == 3'b001) || (s2 == 3'b010) || (s2 == 3'b100);

  assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_MASK : 16'h0000);

  always_ff @(posedge CLK) begin
    if (!RST_N) lfsr <= SEED;
    else        lfsr <= lfsr_next;
  end

  // Fold the 2-bit draw onto three moves; a double miss falls back to move 0.
  always_comb begin
    move_sel = lfsr[1:0];
    if (move_sel == 2'd3) move_sel = lfsr[3:2];
    if (move_sel == 2'd3) move_sel = 2'd0;
    case (move_sel)
      2'd1:    move_pick = 3'b010;
      2'd2:    move_pick = 3'b100;
      default: move_pick = 3'b001;
    endcase
  end

  // NOTE: every signal assigned in this block gets a default first, so no path
  // can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt;
    user_d      = user;
    compu_d     = compu;
    valid_d     = round_valid;
    busy_d      = busy;
    round_cnt_d = round_cnt;
    case (state_q)
      ST_IDLE: begin
        if (stable && s2_one_hot) begin
          state_d     = ST_REVEAL;
          hold_cnt_d  = '0;
          user_d      = s2;
          compu_d     = move_pick;
          valid_d     = 1'b1;
          busy_d      = 1'b1;
          round_cnt_d = round_cnt + 8'd1;
        end
      end
      ST_REVEAL: begin
        hold_cnt_d = hold_cnt + 1'b1;
        if (hold_cnt == HOLD_MAX) begin
          state_d = ST_RELEASE;
          user_d  = 3'b000;
          compu_d = 3'b000;
          valid_d = 1'b0;
        end
      end
      ST_RELEASE: begin
        if (stable && (s2 == 3'b000)) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      hold_cnt    <= '0;
      user        <= 3'b000;
      compu       <= 3'b000;
      round_valid <= 1'b0;
      busy        <= 1'b0;
      round_cnt   <= 8'd0;
    end else begin
      state_q     <= state_d;
      hold_cnt    <= hold_cnt_d;
      user        <= user_d;
      compu       <= compu_d;
      round_valid <= valid_d;
      busy        <= busy_d;
      round_cnt   <= round_cnt_d;
    end
  end

endmodule

// File: tb/tb_rps_move_gen.sv
// Self-checking bench for rps_move_gen: a cycle-level behavioural model of the round
// rules is compared against the DUT every cycle, alongside directed literal checks.
module tb_rps_move_gen;

  localparam int          DB   = 4;
  localparam int          HOLD = 8;
  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] user_raw = 3'b111;
  logic [2:0] user, compu;
  logic       round_valid, busy;
  logic [7:0] round_cnt;

  rps_move_gen #(
    .DEBOUNCE_CYCLES(DB),
    .HOLD_CYCLES    (HOLD),
    .LFSR_SEED      (SEED)
  ) dut (
    .CLK        (clk),
    .RST_N      (rst_n),
    .user_raw   (user_raw),
    .user       (user),
    .compu      (compu),
    .round_valid(round_valid),
    .busy       (busy),
    .round_cnt  (round_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    if (l % 2 == 1) return (l >> 1) ^ 16'hB400;
    return l >> 1;
  endfunction

  function automatic logic [2:0] move_of(input logic [15:0] l);
    int r;
    r = l % 4;
    if (r == 3) r = (l / 4) % 4;
    if (r == 3) r = 0;
    return 3'(1 << r);
  endfunction

  // Behavioural model: m_run counts how many consecutive cycles the synchronized
  // level has held; a level is trusted once it has been seen DB+1 times.
  logic [2:0]  m_user, m_compu, m_s1, m_s, nxt_s;
  logic        m_valid, m_busy;
  int          m_cnt, m_left, m_run, m_rounds = 0;
  logic [15:0] m_lfsr;
  bit          chk_en = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_user = 0; m_compu = 0; m_valid = 0; m_busy = 0;
      m_cnt = 0; m_left = 0; m_lfsr = SEED;
      m_s1 = 0; m_s = 0;
      // Reset zeroes both the synchronized sample and its predecessor.
      m_run = 2;
    end else begin
      if (!m_busy) begin
        if (m_run > DB && (m_s == 3'b001 || m_s == 3'b010 || m_s == 3'b100)) begin
          m_user = m_s;
          m_compu = move_of(m_lfsr);
          m_valid = 1; m_busy = 1;
          m_cnt = (m_cnt + 1) % 256;
          m_left = HOLD;
          m_rounds++;
        end
      end else if (m_valid) begin
        m_left--;
        if (m_left == 0) begin
          m_user = 0; m_compu = 0; m_valid = 0;
        end
      end else if (m_run > DB && m_s == 3'b000) begin
        m_busy = 0;
      end
      m_lfsr = lfsr_step(m_lfsr);
      nxt_s = m_s1;
      m_s1 = user_raw;
      m_run = (nxt_s == m_s) ? ((m_run < 1000) ? m_run + 1 : m_run) : 1;
      m_s = nxt_s;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("outputs{user,compu,valid,busy,cnt}",
            {16'h0, user, compu, round_valid, busy, round_cnt},
            {16'h0, m_user, m_compu, m_valid, m_busy, 8'(m_cnt)});
      if (round_valid) check("compu_onehot", 32'($onehot(compu)), 32'd1);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  int lat, width, b, base, iter;

  initial begin
    // Reset with all buttons pressed
    @(posedge clk);
    #1 chk_en = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {user, compu, round_valid, busy, round_cnt}, 16'h0);

    // Pin the model's LFSR and mapping to hand-computed values
    check("lfsr_step_ace1", lfsr_step(16'hACE1), 16'hE270);
    check("lfsr_step_e270", lfsr_step(16'hE270), 16'h7138);
    check("move_ace1", move_of(16'hACE1), 3'b010);
    check("move_000f", move_of(16'h000F), 3'b001);
    check("move_000b", move_of(16'h000B), 3'b100);

    rst_n = 1'b1;
    user_raw = 3'b000;
    cycles(6);

    // Short glitch, then an illegal multi-hot press
    user_raw = 3'b100; cycles(3);
    user_raw = 3'b000; cycles(10);
    check("glitch_no_round", round_cnt, 0);
    user_raw = 3'b011; cycles(20);
    user_raw = 3'b000; cycles(10);
    check("multihot_no_round", round_cnt, 0);
    check("multihot_idle", busy, 0);

    // Single round: accept latency and reveal width
    user_raw = 3'b010;
    lat = 0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      @(negedge clk);
      if (round_valid) lat = i;
    end
    check("accept_edges_after_first_sample", lat - 1, 6);
    check("round1_user", user, 3'b010);
    check("round1_cnt", round_cnt, 1);
    width = 0; b = 0;
    while (round_valid && b < 40) begin
      width++; b++;
      @(negedge clk);
    end
    check("valid_width", width, HOLD);
    check("after_window_moves", {user, compu}, 6'b0);
    check("after_window_busy", busy, 1);
    cycles(15);
    check("held_button_busy", busy, 1);
    check("held_button_cnt", round_cnt, 1);
    user_raw = 3'b000; cycles(10);
    check("release_to_idle", busy, 0);

    // Release gating: a brief release must not let a new press through
    user_raw = 3'b001;
    b = 0;
    while (!round_valid && b < 30) begin b++; @(negedge clk); end
    b = 0;
    while (round_valid && b < 30) begin b++; @(negedge clk); end
    cycles(3);
    check("gate_busy_held", busy, 1);
    user_raw = 3'b000; cycles(2);
    user_raw = 3'b100; cycles(12);
    check("gate_no_retrigger_cnt", round_cnt, 2);
    check("gate_no_retrigger_busy", busy, 1);
    user_raw = 3'b000;
    cycles(6);
    check("gate_busy_before_4_zero_samples", busy, 1);
    cycles(1);
    check("gate_idle_after_4_zero_samples", busy, 0);
    user_raw = 3'b100;
    b = 0;
    while (!round_valid && b < 30) begin b++; @(negedge clk); end
    check("gate_second_round_cnt", round_cnt, 3);
    check("gate_second_round_user", user, 3'b100);

    // Reset on the third REVEAL cycle
    cycles(2);
    rst_n = 1'b0;
    cycles(1);
    check("midreveal_valid", round_valid, 0);
    check("midreveal_cnt", round_cnt, 0);
    check("midreveal_busy", busy, 0);
    rst_n = 1'b1;
    user_raw = 3'b000;
    cycles(6);

    // Randomized rounds until the counter wraps
    base = m_rounds;
    iter = 0;
    while (m_rounds - base < 256 && iter < 2500) begin
      iter++;
      if ($urandom_range(0, 9) < 8) begin
        user_raw = 3'(1 << $urandom_range(0, 2));
        cycles($urandom_range(3, 20));
      end else begin
        user_raw = 3'($urandom_range(0, 7));
        cycles($urandom_range(1, 6));
      end
      user_raw = 3'b000;
      cycles($urandom_range(2, 10));
    end
    check("wrap_round_total", m_rounds - base, 256);
    check("wrap_cnt_zero", round_cnt, 0);
    cycles(20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
